button_led_ctrl: RTL and testbench
==================================

BUTTON_LED_CTRL -- requirements
Module: button_led_ctrl

Interface
REQ-001 Parameter N_CH, default 3: number of independent button/LED channels, 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 120000: stability interval in clk cycles (10 ms at 12 MHz), >= 1.
REQ-003 Parameter TOGGLE_MODE, default 0: 0 = momentary (LED follows button), 1 = toggle (each press flips LED).
REQ-004 Parameter BTN_ACTIVE_LOW, default 1: 1 = pressed button reads 0 at the pin.
REQ-005 Parameter LED_ACTIVE_LOW, default 1: 1 = LED lit when pin driven 0.
REQ-006 clk  input  1  single system clock; all logic on the rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 button  input  N_CH  raw asynchronous button pins, bit i = channel i.
REQ-009 led  output  N_CH  LED drive pins, bit i = channel i, polarity per LED_ACTIVE_LOW.
REQ-010 press  output  N_CH  one-cycle pulse per debounced press, active-high, independent of pin polarity.

Function
REQ-011 Each channel SHALL pass button through a 2-flop synchroniser, then normalise so that 1 = pressed (invert when BTN_ACTIVE_LOW=1).
REQ-012 Each channel SHALL hold a debounced state `stable` and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 When the normalised sync level equals `stable`, the counter SHALL clear to 0.
REQ-014 When the levels differ and the counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-015 When the levels differ and the counter = DEBOUNCE_CYCLES-1, `stable` SHALL take the sync level and the counter SHALL clear; the counter never wraps.
REQ-016 Latency: a pin level held constant SHALL update `stable` on the (DEBOUNCE_CYCLES+2)th rising edge after the change.
REQ-017 Any bounce back to the `stable` level before that edge SHALL restart the interval from zero.
REQ-018 press[i] SHALL be high for exactly the one cycle after `stable` goes 0->1; a release SHALL produce no pulse.
REQ-019 TOGGLE_MODE=0: the logical LED state SHALL equal `stable`.
REQ-020 TOGGLE_MODE=1: the logical LED state SHALL flip on the clock edge at which press[i] is high. It SHALL hold otherwise.
REQ-021 led[i] SHALL be the logical LED state XOR LED_ACTIVE_LOW, driven from registers with no combinational path from button.
REQ-022 Channels SHALL be fully independent: simultaneous presses on several channels SHALL each debounce, pulse and toggle correctly in the same cycles.

Reset
REQ-023 While rst=1 at a clock edge: synchroniser flops SHALL load the normalised released level (0), `stable`=0, counters=0, edge-detect history=0, toggle state=0.
REQ-024 During and after reset: press=0, led = all LEDs off (all 1s when LED_ACTIVE_LOW=1).
REQ-025 Reset asserted mid-debounce SHALL discard the partial count. A button held through reset release SHALL be treated as a new press after the full interval, with a press pulse.

Verification (DEBOUNCE_CYCLES=4, N_CH=3, active-low pins)
REQ-026 Reset, all buttons=1 -> led=3'b111, press=0 for 20 cycles.
REQ-027 Momentary mode, button[0] 1->0 held -> press[0] high for 1 cycle and led[0]=0 per REQ-016/018/019; button[0] released -> led[0]=1 after the same latency, no pulse.
REQ-028 Bounce: button[1] low 3 cycles, high 1, low held -> only one press[1] pulse, timed from the final falling edge.
REQ-029 Toggle mode, three clean presses on button[2] -> led[2] sequence 0,1,0 (lit, off, lit); one press pulse each.
REQ-030 All three buttons pressed in the same cycle -> press=3'b111 in a single cycle.
REQ-031 rst pulsed during a held press at count 2 -> no pulse before reset; pulse after DEBOUNCE_CYCLES+2 edges post-reset.

Source files
------------

// File: rtl/button_led_ctrl.sv
// Multi-channel button debouncer with press pulse and LED driver.
// Each channel: 2-flop synchroniser on the polarity-normalised pin level,
// a stability counter that commits the level to `stable` after
// DEBOUNCE_CYCLES consecutive differing samples, a rising-edge press pulse,
// and an LED that either mirrors `stable` (momentary) or flips on each
// press (toggle). Channels share nothing but clk and rst.
module button_led_ctrl #(
  parameter int N_CH            = 3,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter bit TOGGLE_MODE     = 1'b0,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter bit LED_ACTIVE_LOW  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_CH-1:0] BTN_INV = {N_CH{BTN_ACTIVE_LOW}};
  localparam logic [N_CH-1:0] LED_INV = {N_CH{LED_ACTIVE_LOW}};

  logic [N_CH-1:0] sync1;     // first synchroniser stage, 1 = pressed
  logic [N_CH-1:0] sync2;     // second synchroniser stage, 1 = pressed
  logic [N_CH-1:0] stable;    // debounced level
  logic [N_CH-1:0] stable_d;  // previous debounced level for edge detect
  logic [N_CH-1:0] tog;       // toggle-mode LED state
  logic [CW-1:0]   cnt [N_CH];

  // Synchronise the normalised pin level; reset loads the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= button ^ BTN_INV;
      sync2 <= sync1;
    end
  end

  // Per-channel stability counter; any sample equal to `stable` restarts
  // the interval, and the counter clears on commit so it never wraps.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (rst) begin
        stable[i] <= 1'b0;
        cnt[i]    <= '0;
      end else if (sync2[i] == stable[i]) begin
        cnt[i] <= '0;
      end else if (cnt[i] == LAST) begin
        stable[i] <= sync2[i];
        cnt[i]    <= '0;
      end else begin
        cnt[i] <= cnt[i] + CW'(1);
      end
    end
  end

  // Edge-detect history for the press pulse.
  always_ff @(posedge clk) begin
    if (rst) stable_d <= '0;
    else     stable_d <= stable;
  end

  // Press is high for the one cycle after `stable` rises; both terms are
  // registers so there is no combinational path from the pins.
  assign press = stable & ~stable_d;

  // Toggle state flips on the edge where the press pulse is high.
  always_ff @(posedge clk) begin
    if (rst) tog <= '0;
    else     tog <= tog ^ press;
  end

  // LED pin: logical state (register) adjusted for drive polarity.
  assign led = (TOGGLE_MODE ? tog : stable) ^ LED_INV;

endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed bench for button_led_ctrl with DEBOUNCE_CYCLES=4, N_CH=3,
// active-low button and LED pins. One momentary instance and one toggle
// instance share clock and reset; each has its own button vector.
module tb_button_led_ctrl;

  localparam int N  = 3;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_m = '1;
  logic [N-1:0] btn_t = '1;
  logic [N-1:0] led_m, press_m, led_t, press_t;

  int checks = 0;
  int errors = 0;
  int pulses_m [N];
  int pulses_t [N];

  // Clock and reset
  always #5 clk = ~clk;

  button_led_ctrl #(.N_CH(N), .DEBOUNCE_CYCLES(DC), .TOGGLE_MODE(1'b0),
                    .BTN_ACTIVE_LOW(1'b1), .LED_ACTIVE_LOW(1'b1)) dut_m (
    .clk(clk), .rst(rst), .button(btn_m), .led(led_m), .press(press_m));

  button_led_ctrl #(.N_CH(N), .DEBOUNCE_CYCLES(DC), .TOGGLE_MODE(1'b1),
                    .BTN_ACTIVE_LOW(1'b1), .LED_ACTIVE_LOW(1'b1)) dut_t (
    .clk(clk), .rst(rst), .button(btn_t), .led(led_t), .press(press_t));

  // Advance n rising edges, settle 1ns past each, and tally press pulses.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (press_m[c]) pulses_m[c]++;
        if (press_t[c]) pulses_t[c]++;
      end
    end
  endtask

  task automatic clear_pulses();
    for (int c = 0; c < N; c++) begin
      pulses_m[c] = 0;
      pulses_t[c] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear_pulses();

    // Reset with all buttons released: LEDs off, no press for 20 cycles.
    tick(1);
    chk("reset_led", 32'(led_m), 32'h7);
    chk("reset_press", 32'(press_m), 32'h0);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      chk("reset_hold_led", 32'(led_m), 32'h7);
      chk("reset_hold_press", 32'(press_m), 32'h0);
    end
    rst = 1'b0;
    tick(10);
    chk("idle_led_m", 32'(led_m), 32'h7);
    chk("idle_led_t", 32'(led_t), 32'h7);
    clear_pulses();

    // Momentary press on channel 0: stable at edge DC+2 after the change.
    btn_m[0] = 1'b0;
    tick(DC + 1);
    chk("m0_before_led", 32'(led_m), 32'h7);
    chk("m0_before_pulses", 32'(pulses_m[0]), 32'd0);
    tick(1);
    chk("m0_press", 32'(press_m), 32'h1);
    chk("m0_led", 32'(led_m), 32'h6);
    tick(1);
    chk("m0_press_gone", 32'(press_m), 32'h0);
    chk("m0_led_held", 32'(led_m), 32'h6);
    // Release: LED off after the same latency, no pulse.
    btn_m[0] = 1'b1;
    tick(DC + 1);
    chk("m0_rel_before", 32'(led_m), 32'h6);
    tick(1);
    chk("m0_rel_led", 32'(led_m), 32'h7);
    tick(5);
    chk("m0_total_pulses", 32'(pulses_m[0]), 32'd1);
    clear_pulses();

    // Bounce on channel 1: low 3, high 1, then low held.
    btn_m[1] = 1'b0;
    tick(3);
    btn_m[1] = 1'b1;
    tick(1);
    btn_m[1] = 1'b0;
    tick(DC + 1);
    chk("b1_no_early_pulse", 32'(pulses_m[1]), 32'd0);
    chk("b1_before_led", 32'(led_m), 32'h7);
    tick(1);
    chk("b1_press", 32'(press_m), 32'h2);
    chk("b1_led", 32'(led_m), 32'h5);
    tick(8);
    chk("b1_total_pulses", 32'(pulses_m[1]), 32'd1);
    btn_m[1] = 1'b1;
    tick(10);
    chk("b1_released_led", 32'(led_m), 32'h7);
    clear_pulses();

    // Toggle mode: three clean presses on channel 2 -> lit, off, lit.
    btn_t[2] = 1'b0;
    tick(DC + 2);
    chk("t_press1_pulse", 32'(press_t), 32'h4);
    chk("t_press1_led_pre", 32'(led_t), 32'h7);
    tick(1);
    chk("t_led_1", 32'(led_t), 32'h3);
    btn_t[2] = 1'b1;
    tick(10);
    chk("t_led_1_hold", 32'(led_t), 32'h3);
    btn_t[2] = 1'b0;
    tick(DC + 3);
    chk("t_led_2", 32'(led_t), 32'h7);
    btn_t[2] = 1'b1;
    tick(10);
    btn_t[2] = 1'b0;
    tick(DC + 3);
    chk("t_led_3", 32'(led_t), 32'h3);
    btn_t[2] = 1'b1;
    tick(10);
    chk("t_led_3_hold", 32'(led_t), 32'h3);
    chk("t_pulses", 32'(pulses_t[2]), 32'd3);
    chk("t_pulses_m_idle", 32'(pulses_m[2]), 32'd0);
    clear_pulses();

    // All three channels pressed in the same cycle.
    btn_m = 3'b000;
    tick(DC + 1);
    chk("all_before", 32'(press_m), 32'h0);
    tick(1);
    chk("all_press", 32'(press_m), 32'h7);
    chk("all_led", 32'(led_m), 32'h0);
    tick(1);
    chk("all_press_gone", 32'(press_m), 32'h0);
    btn_m = 3'b111;
    tick(10);
    chk("all_released", 32'(led_m), 32'h7);
    clear_pulses();

    // Reset in the middle of a held press (counter at 2).
    btn_m[0] = 1'b0;
    tick(4);
    chk("rst_mid_no_pulse", 32'(pulses_m[0]), 32'd0);
    rst = 1'b1;
    tick(2);
    chk("rst_mid_led", 32'(led_m), 32'h7);
    chk("rst_mid_press", 32'(press_m), 32'h0);
    rst = 1'b0;
    tick(DC + 1);
    chk("post_rst_before", 32'(pulses_m[0]), 32'd0);
    tick(1);
    chk("post_rst_press", 32'(press_m), 32'h1);
    chk("post_rst_led", 32'(led_m), 32'h6);
    tick(5);
    chk("post_rst_pulses", 32'(pulses_m[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
